// File: rtl/moving_wall_engine.sv
// -----------------------------------------------------------------------------
// moving_wall_engine
//
// Table-driven wall generator for the VGA level renderer. Holds NUM_WALLS
// rectangles, each with a position, size, signed horizontal velocity and a
// motion mode. Every clock it produces one registered hit bit per wall for the
// current pixel. On each rising edge of the frame tick it sweeps the table one
// entry per cycle, moving enabled walls that wrap or bounce. The level
// controller loads entries at run time through the config write port.
//
// Ports:
//   clk       in   system pixel clock
//   rst       in   synchronous, active-high reset
//   update    in   frame tick level; rising edge starts a sweep
//   xCount    in   current pixel column
//   yCount    in   current pixel row
//   cfg_we    in   write strobe for one table entry
//   cfg_idx   in   entry written (indices >= NUM_WALLS are ignored)
//   cfg_x/y   in   top-left corner of the rectangle
//   cfg_w/h   in   rectangle size
//   cfg_dx    in   signed horizontal velocity, pixels per update
//   cfg_mode  in   0 static, 1 wrap, 2 bounce, 3 reserved (static)
//   cfg_en    in   entry enable
//   wall      out  per-wall hit for the pixel presented one cycle earlier
//   busy      out  sweep in progress
//   overrun   out  sticky: an update edge arrived while a sweep was running
// -----------------------------------------------------------------------------
module moving_wall_engine #(
  parameter int NUM_WALLS = 26,
  parameter int IDXW      = 6,
  parameter int XW        = 10,
  parameter int SCREEN_W  = 640,
  parameter int VW        = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 update,
  input  logic [XW-1:0]        xCount,
  input  logic [XW-1:0]        yCount,
  input  logic                 cfg_we,
  input  logic [IDXW-1:0]      cfg_idx,
  input  logic [XW-1:0]        cfg_x,
  input  logic [XW-1:0]        cfg_y,
  input  logic [XW-1:0]        cfg_w,
  input  logic [XW-1:0]        cfg_h,
  input  logic signed [VW-1:0] cfg_dx,
  input  logic [1:0]           cfg_mode,
  input  logic                 cfg_en,
  output logic [NUM_WALLS-1:0] wall,
  output logic                 busy,
  output logic                 overrun
);

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_WRAP   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

  typedef struct packed {
    logic                 en;
    mode_t                mode;
    logic signed [VW-1:0] dx;
    logic [XW-1:0]        x;
    logic [XW-1:0]        y;
    logic [XW-1:0]        w;
    logic [XW-1:0]        h;
  } entry_t;

  typedef enum logic {
    S_IDLE,
    S_SWEEP
  } state_t;

  // Motion arithmetic width: XW+2 holds x+dx as a signed value, one more bit
  // keeps x+dx+w from overflowing in the bounce test.
  localparam int                    SW       = XW + 3;
  localparam logic [IDXW-1:0]       LAST_IDX = IDXW'(NUM_WALLS - 1);
  localparam logic signed [SW-1:0]  SCREEN   = SW'(SCREEN_W);
  localparam logic signed [VW-1:0]  DX_MIN   = {1'b1, {(VW-1){1'b0}}};
  localparam logic signed [VW-1:0]  DX_MAX   = {1'b0, {(VW-1){1'b1}}};

  entry_t               tbl_q [NUM_WALLS];
  state_t               state_q, state_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic                 update_q;
  logic                 start;
  logic                 sweep_we;
  logic                 cfg_hit;

  entry_t               cur;
  logic signed [SW-1:0] n;
  logic signed [SW-1:0] n_end;
  logic [XW-1:0]        x_new;
  logic signed [VW-1:0] dx_new;

  assign start   = update & ~update_q;
  assign busy    = (state_q == S_SWEEP);
  assign cfg_hit = cfg_we && (cfg_idx <= LAST_IDX);

  // ---------------------------------------------------------------------------
  // Sweep FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment uses <= so all registers update from
    // the values seen before the edge, independent of statement order.
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      update_q <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      update_q <= update;
      if (start && busy) begin
        overrun <= 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: defaults first, so no path through the case leaves an output
    // unassigned and infers a latch.
    state_d  = state_q;
    idx_d    = idx_q;
    sweep_we = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SWEEP;
          idx_d   = '0;
        end
      end
      S_SWEEP: begin
        sweep_we = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Motion of the entry under the sweep index
  // ---------------------------------------------------------------------------
  always_comb begin
    cur    = tbl_q[idx_q];
    n      = $signed({3'b000, cur.x}) + $signed({{(SW-VW){cur.dx[VW-1]}}, cur.dx});
    n_end  = n + $signed({3'b000, cur.w});
    x_new  = cur.x;
    dx_new = cur.dx;
    if (cur.en) begin
      case (cur.mode)
        MODE_WRAP: begin
          if (n < 0) begin
            x_new = XW'(n + SCREEN);
          end else if (n >= SCREEN) begin
            x_new = XW'(n - SCREEN);
          end else begin
            x_new = XW'(n);
          end
        end
        MODE_BOUNCE: begin
          if (n < 0 || n_end > SCREEN) begin
            // Reverse in place; the most negative velocity has no positive
            // twin, so it saturates to the largest positive one.
            dx_new = (cur.dx == DX_MIN) ? DX_MAX : -cur.dx;
          end else begin
            x_new = XW'(n);
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Wall table
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the table is a register file, not a RAM, so it can be and is
      // cleared on reset; a reset loop over a RAM would block RAM inference.
      for (int i = 0; i < NUM_WALLS; i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      if (sweep_we) begin
        tbl_q[idx_q].x  <= x_new;
        tbl_q[idx_q].dx <= dx_new;
      end
      // Placed after the sweep update: when both target the same entry the
      // config write is the one that lands.
      if (cfg_hit) begin
        tbl_q[cfg_idx] <= '{en:   cfg_en,
                            mode: mode_t'(cfg_mode),
                            dx:   cfg_dx,
                            x:    cfg_x,
                            y:    cfg_y,
                            w:    cfg_w,
                            h:    cfg_h};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Rendering: one registered hit bit per wall. Right/bottom edges are summed
  // at XW+1 bits so rectangles running past 2^XW do not wrap to column 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wall <= '0;
    end else begin
      for (int i = 0; i < NUM_WALLS; i++) begin
        wall[i] <= tbl_q[i].en
                 & (xCount > tbl_q[i].x)
                 & ({1'b0, xCount} < ({1'b0, tbl_q[i].x} + {1'b0, tbl_q[i].w}))
                 & (yCount > tbl_q[i].y)
                 & ({1'b0, yCount} < ({1'b0, tbl_q[i].y} + {1'b0, tbl_q[i].h}));
      end
    end
  end

endmodule

// File: tb/tb_moving_wall_engine.sv
// -----------------------------------------------------------------------------
// tb_moving_wall_engine
//
// Directed and randomized checks of moving_wall_engine against a small
// behavioural model of the wall table kept as plain integer arrays.
// -----------------------------------------------------------------------------
module tb_moving_wall_engine;

  localparam int N  = 26;
  localparam int SW = 640;

  logic              clk = 1'b0;
  logic              rst;
  logic              update;
  logic [9:0]        xCount;
  logic [9:0]        yCount;
  logic              cfg_we;
  logic [5:0]        cfg_idx;
  logic [9:0]        cfg_x, cfg_y, cfg_w, cfg_h;
  logic signed [3:0] cfg_dx;
  logic [1:0]        cfg_mode;
  logic              cfg_en;
  logic [N-1:0]      wall;
  logic              busy;
  logic              overrun;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference table
  int m_x [N];
  int m_y [N];
  int m_w [N];
  int m_h [N];
  int m_dx[N];
  int m_mode[N];
  bit m_en[N];

  moving_wall_engine dut (
    .clk      (clk),
    .rst      (rst),
    .update   (update),
    .xCount   (xCount),
    .yCount   (yCount),
    .cfg_we   (cfg_we),
    .cfg_idx  (cfg_idx),
    .cfg_x    (cfg_x),
    .cfg_y    (cfg_y),
    .cfg_w    (cfg_w),
    .cfg_h    (cfg_h),
    .cfg_dx   (cfg_dx),
    .cfg_mode (cfg_mode),
    .cfg_en   (cfg_en),
    .wall     (wall),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hit vector the spec's rectangle rule gives for pixel (px, py).
  function automatic logic [N-1:0] model_wall(input int px, input int py);
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      v[i] = m_en[i] && (px > m_x[i]) && (px < m_x[i] + m_w[i])
                     && (py > m_y[i]) && (py < m_y[i] + m_h[i]);
    end
    return v;
  endfunction

  // One frame update of the whole table; 'skip' marks an entry overwritten
  // by a config write during the sweep.
  task automatic model_sweep(input int skip);
    int nx;
    for (int i = 0; i < N; i++) begin
      if (i != skip && m_en[i]) begin
        nx = m_x[i] + m_dx[i];
        if (m_mode[i] == 1) begin
          if (nx < 0)        m_x[i] = nx + SW;
          else if (nx >= SW) m_x[i] = nx - SW;
          else               m_x[i] = nx;
        end else if (m_mode[i] == 2) begin
          if (nx < 0 || nx + m_w[i] > SW) m_dx[i] = (m_dx[i] == -8) ? 7 : -m_dx[i];
          else                             m_x[i] = nx;
        end
      end
    end
  endtask

  task automatic cfg_write(input int idx, input int x, input int y, input int w,
                           input int h, input int dx, input int mode, input bit en);
    cfg_idx  = idx[5:0];
    cfg_x    = x[9:0];
    cfg_y    = y[9:0];
    cfg_w    = w[9:0];
    cfg_h    = h[9:0];
    cfg_dx   = dx[3:0];
    cfg_mode = mode[1:0];
    cfg_en   = en;
    cfg_we   = 1'b1;
    tick();
    cfg_we   = 1'b0;
    if (idx < N) begin
      m_x[idx] = x; m_y[idx] = y; m_w[idx] = w; m_h[idx] = h;
      m_dx[idx] = dx; m_mode[idx] = mode; m_en[idx] = en;
    end
  endtask

  task automatic probe(input string tag, input int px, input int py);
    xCount = px[9:0];
    yCount = py[9:0];
    tick();
    check(tag, wall, model_wall(px, py));
  endtask

  task automatic probe_bit(input string tag, input int px, input int py,
                           input int i, input logic exp);
    xCount = px[9:0];
    yCount = py[9:0];
    tick();
    check(tag, wall[i], exp);
  endtask

  // Starts a sweep, checks it lasts exactly N busy cycles, updates the model.
  task automatic run_sweep(input string tag);
    int cyc;
    update = 1'b1;
    tick();
    update = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      tick();
      cyc++;
    end
    check(tag, cyc, N);
    model_sweep(-1);
  endtask

  initial begin
    int cyc;
    int e, px, py;

    // ---------------- reset with every input active ----------------
    rst = 1'b1; update = 1'b1; cfg_we = 1'b1; cfg_idx = '0;
    cfg_x = 10'd5; cfg_y = 10'd46; cfg_w = 10'd600; cfg_h = 10'd20;
    cfg_dx = 4'sd3; cfg_mode = 2'd1; cfg_en = 1'b1;
    xCount = 10'd6; yCount = 10'd47;
    repeat (3) tick();
    check("rst_wall", wall, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    rst = 1'b0; update = 1'b0; cfg_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_wall", wall, '0);
      check("post_rst_busy", busy, 1'b0);
      check("post_rst_overrun", overrun, 1'b0);
    end
    run_sweep("rst_sweep_len");
    probe("rst_sweep_wall", 6, 47);
    probe("rst_sweep_wall2", 300, 300);

    // ---------------- static render ----------------
    cfg_write(0, 5, 46, 600, 20, 0, 0, 1'b1);
    probe_bit("static_in", 6, 47, 0, 1'b1);
    probe_bit("static_left", 5, 47, 0, 1'b0);
    probe_bit("static_right", 605, 47, 0, 1'b0);
    probe_bit("static_bottom", 6, 66, 0, 1'b0);
    probe_bit("static_corner", 604, 65, 0, 1'b1);
    probe("static_vec", 6, 47);

    // ---------------- wrap and bounce ----------------
    cfg_write(1, 630, 100, 5, 5, 7, 1, 1'b1);
    cfg_write(2, 10, 300, 20, 5, -6, 2, 1'b1);
    cfg_write(3, 3, 200, 5, 5, -7, 1, 1'b1);
    run_sweep("sweep1_len");
    probe_bit("wrap_637_in", 638, 101, 1, 1'b1);
    probe_bit("wrap_637_edge", 637, 101, 1, 1'b0);
    probe_bit("wrapneg_636_in", 637, 201, 3, 1'b1);
    probe_bit("wrapneg_636_edge", 636, 201, 3, 1'b0);
    probe_bit("bounce_4_in", 5, 301, 2, 1'b1);
    probe_bit("bounce_4_edge", 4, 301, 2, 1'b0);
    run_sweep("sweep2_len");
    probe_bit("wrap_4_in", 5, 101, 1, 1'b1);
    probe_bit("wrap_4_edge", 4, 101, 1, 1'b0);
    probe_bit("bounce_hold_in", 5, 301, 2, 1'b1);
    probe_bit("bounce_hold_edge", 4, 301, 2, 1'b0);
    run_sweep("sweep3_len");
    probe_bit("bounce_10_in", 11, 301, 2, 1'b1);
    probe_bit("bounce_10_edge", 10, 301, 2, 1'b0);
    probe("wb_vec", 11, 301);

    // ---------------- sweep length and overrun ----------------
    check("ovr_pre", overrun, 1'b0);
    update = 1'b1;
    tick();
    update = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      if (cyc == 9) update = 1'b1;
      tick();
      cyc++;
    end
    check("ovr_busy_len", cyc, N);
    check("ovr_set", overrun, 1'b1);
    model_sweep(-1);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy) cyc++;
    end
    check("held_no_sweep", cyc, 0);
    update = 1'b0;
    tick();
    check("ovr_sticky", overrun, 1'b1);
    probe("ovr_vec", 11, 301);

    // ---------------- config write collides with the sweep ----------------
    cfg_write(5, 100, 400, 10, 5, 3, 1, 1'b1);
    update = 1'b1;
    tick();
    update = 1'b0;
    repeat (5) tick();
    check("coll_busy", busy, 1'b1);
    cfg_write(5, 200, 400, 10, 5, 3, 1, 1'b1);
    cyc = 0;
    while (busy && cyc < 100) begin
      tick();
      cyc++;
    end
    check("coll_done", busy, 1'b0);
    model_sweep(5);
    probe_bit("coll_in", 201, 401, 5, 1'b1);
    probe_bit("coll_edge", 200, 401, 5, 1'b0);

    // ---------------- out-of-range index ----------------
    cfg_write(40, 0, 0, 1023, 1023, 0, 0, 1'b1);
    probe("oor_vec1", 500, 500);
    probe("oor_vec2", 201, 401);

    // ---------------- randomized tables against the model ----------------
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          cfg_write(i, $urandom_range(0, 1023), $urandom_range(0, 700),
                    $urandom_range(2, 300), $urandom_range(2, 200),
                    int'($urandom_range(0, 15)) - 8, $urandom_range(0, 3),
                    bit'($urandom_range(0, 3) != 0));
        end
      end
      run_sweep("rand_sweep_len");
      for (int k = 0; k < 6; k++) begin
        e  = $urandom_range(0, N - 1);
        px = (m_x[e] + int'($urandom_range(0, 3)) - 1) & 1023;
        py = (m_y[e] + int'($urandom_range(0, m_h[e]))) & 1023;
        probe("rand_vec", px, py);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/moving_wall_engine.md
Name: moving_wall_engine

Overview:
- Parametrised successor to the fixed level-wall generators: holds a table of NUM_WALLS rectangles, each with its own position, size, horizontal velocity and motion mode.
- Renders one registered hit bit per wall for the current VGA pixel (xCount, yCount).
- On each frame update, advances every enabled moving wall with a sequential one-wall-per-cycle sweep.
- The table is loaded at run time from the level controller through a config write port, replacing hard-coded positions.

Parameters:
- NUM_WALLS, 26: number of wall entries (1..64).
- IDXW, 6: width of wall index; must satisfy 2^IDXW >= NUM_WALLS.
- XW, 10: pixel coordinate width.
- SCREEN_W, 640: horizontal wrap/bounce limit in pixels.
- VW, 4: signed velocity width (two's complement, pixels per update).

Ports:
- clk  in  1  system pixel clock.
- rst  in  1  synchronous, active-high reset.
- update  in  1  frame tick level; a rising edge, detected on clk, starts a sweep.
- xCount  in  XW  current pixel column.
- yCount  in  XW  current pixel row.
- cfg_we  in  1  write strobe for one table entry.
- cfg_idx  in  IDXW  entry written.
- cfg_x, cfg_y, cfg_w, cfg_h  in  XW each  position and size.
- cfg_dx  in  VW  signed horizontal velocity.
- cfg_mode  in  2  0 static, 1 wrap, 2 bounce, 3 reserved (treated as static).
- cfg_en  in  1  entry enable.
- wall  out  NUM_WALLS  per-wall hit for the current pixel.
- busy  out  1  sweep in progress.
- overrun  out  1  sticky; update edge arrived while busy.

Behaviour:
- Reset, synchronous on clk with rst=1:
  - All entries cleared (en=0, x=y=w=h=dx=mode=0).
  - wall=0, busy=0, overrun=0, sweep index=0, edge-detect register=0.
  - A sweep in progress is aborted.
- Rendering:
  - wall[i] <= en_i & (xCount > x_i) & (xCount < x_i+w_i) & (yCount > y_i) & (yCount < y_i+h_i).
  - Strict inequalities.
  - Sums are computed at XW+1 bits, so a rectangle extending past 2^XW does not alias to the left edge.
  - Latency is exactly one clk from xCount/yCount to wall.
  - Rendering runs every cycle, including during a sweep, and uses current table contents.
- Edge detect:
  - update_q <= update each cycle.
  - A start event is update & ~update_q.
- Sweep FSM states:
  - IDLE: on a start event, go to SWEEP with idx=0 and busy=1.
  - SWEEP: process entry idx in one cycle. If idx==NUM_WALLS-1, go to IDLE with busy=0; otherwise idx+1.
  - A sweep takes exactly NUM_WALLS cycles; busy is high during those cycles.
  - A start event while busy does not restart the sweep; it sets overrun=1.
  - overrun clears only on rst.
- Per-entry motion (entry idx, n = x + sign-extended dx, computed signed at XW+2 bits):
  - en=0 or mode 0/3: no change.
  - Wrap (mode 1): n<0 gives x=n+SCREEN_W; n>=SCREEN_W gives x=n-SCREEN_W; otherwise x=n.
  - Bounce (mode 2): n<0 or n+w>SCREEN_W gives dx=-dx with x unchanged; otherwise x=n.
  - dx at the most negative value is negated with saturation to +max.
- Config write:
  - cfg_we=1 writes all fields of entry cfg_idx in one cycle, in any FSM state.
  - cfg_idx >= NUM_WALLS is ignored.
  - If the write targets the entry the sweep processes in the same cycle, the config write wins; that entry is not moved this sweep.
- Simultaneous rst and any other input: rst wins.

Test Plan:
- Reset with all inputs active, then release: wall=0, busy=0, overrun=0 for the next 3 cycles; a start edge afterwards leaves all entries unchanged because en=0.
- Static render: entry 0 {x=5,y=46,w=600,h=20,en=1,mode=0}; pixel (6,47) gives wall[0]=1 one cycle later; pixels (5,47), (605,47) and (6,66) give 0.
- Wrap: entry 1 {x=630,dx=+7,mode=1}; after one sweep x=637, after the next x=4. A second entry with dx=-7 starting at x=3 goes to x=636.
- Bounce: entry 2 {x=10,w=20,dx=-6,mode=2}; sweeps give x=4, then x=4 with dx=+6, then x=10.
- Sweep timing and overrun with NUM_WALLS=26: busy is high for exactly 26 cycles after the start edge. A second edge at cycle 10 sets overrun=1 and does not extend busy. Holding update high produces no further sweep.
- Collision and range: a cfg write to idx=5 in the cycle the sweep processes idx 5 stores the written x unmodified; a cfg write with idx=40 changes nothing.
